// File: rtl/rsa_result_serializer.sv
// Captures a finished RSA ciphertext and streams it MSB byte first over a
// valid/ready byte interface, zeroizing the capture buffer as bytes drain.
module rsa_result_serializer #(
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] encrypted_message,
   input  logic              done,
   output logic [7:0]        out_byte,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              overrun,
   input  logic              ovr_clr
);

   localparam int NBYTES = DATA_W / 8;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] buf_q, buf_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              done_q;
   logic              overrun_q, overrun_d;
   logic              done_rise;
   logic              last_byte;
   logic              ovr_set;

   // done_q resets high so a done level present at reset release is not an edge
   assign done_rise = done & ~done_q;
   assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         buf_q     <= '0;
         idx_q     <= '0;
         done_q    <= 1'b1;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         buf_q     <= buf_d;
         idx_q     <= idx_d;
         done_q    <= done;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      idx_d   = idx_q;
      ovr_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (done_rise) begin
               buf_d   = encrypted_message;
               idx_d   = '0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (out_ready) begin
               buf_d = buf_q << 8;
               idx_d = idx_q + 1'b1;
               if (last_byte) begin
                  // a result landing on the final transfer chains with no gap
                  idx_d = '0;
                  if (done_rise) begin
                     buf_d = encrypted_message;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else if (done_rise) begin
                  ovr_set = 1'b1;
               end
            end else if (done_rise) begin
               ovr_set = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign overrun_d = ovr_set | (overrun_q & ~ovr_clr);

   assign out_valid = (state_q == S_SEND);
   assign out_byte  = out_valid ? buf_q[DATA_W-1 -: 8] : 8'h00;
   assign out_last  = out_valid & last_byte;
   assign busy      = out_valid;
   assign overrun   = overrun_q;

endmodule
